// File: rtl/reorder_buffer_mw.sv
// Multi-wide reorder buffer between rename/dispatch and commit.
// Latency: an entry is allocated at edge N. Its writeback can land at edge N+1 at the earliest.
//   It then retires at edge N+2 at the earliest.
// Backpressure: alloc_ready drops as a whole when fewer than DISPATCH_W slots are free, or during a flush.
//   There is no backpressure on commit.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   alloc_valid/ready     per-slot allocate request (contiguous from bit 0) / all slots accepted
//   alloc_dest_areg/preg  per-slot arch dest, new physical dest
//   alloc_old_preg        per-slot previous mapping, handed back on commit
//   alloc_tag             tag assigned to each slot (tail+i), combinational
//   wb_valid/tag/exc      per-port completion strobe, tag, exception flag
//   flush_in              external mispredict flush, discards every entry
//   commit_valid/areg/... per-slot retirement this edge, contiguous from bit 0
//   exc_flush, exc_tag    one-cycle precise exception flush pulse and the excepting tag
//   count, empty, full    occupancy

module reorder_buffer_mw #(
  parameter int DEPTH      = 16,
  parameter int TAG_W      = 4,
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int WB_PORTS   = 2,
  parameter int AREG_W     = 5,
  parameter int PREG_W     = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DISPATCH_W-1:0]        alloc_valid,
  output logic                         alloc_ready,
  input  logic [DISPATCH_W*AREG_W-1:0] alloc_dest_areg,
  input  logic [DISPATCH_W*PREG_W-1:0] alloc_dest_preg,
  input  logic [DISPATCH_W*PREG_W-1:0] alloc_old_preg,
  output logic [DISPATCH_W*TAG_W-1:0]  alloc_tag,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS-1:0]          wb_exc,
  input  logic                         flush_in,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*AREG_W-1:0]   commit_areg,
  output logic [COMMIT_W*PREG_W-1:0]   commit_preg,
  output logic [COMMIT_W*PREG_W-1:0]   commit_old_preg,
  output logic                         exc_flush,
  output logic [TAG_W-1:0]             exc_tag,
  output logic [TAG_W:0]               count,
  output logic                         empty,
  output logic                         full
);

  localparam int CNT_W = TAG_W + 1;

  logic [DEPTH-1:0]  e_valid, e_done, e_exc;
  logic [AREG_W-1:0] e_areg [DEPTH];
  logic [PREG_W-1:0] e_preg [DEPTH];
  logic [PREG_W-1:0] e_old  [DEPTH];

  logic [TAG_W-1:0]  head, tail;
  logic              exc_pend;
  logic [CNT_W-1:0]  nalloc, ncommit;
  logic [DEPTH-1:0]  wb_hit, wb_exc_hit;
  logic              chain;
  logic [TAG_W-1:0]  cidx;
  logic [TAG_W-1:0]  wtag;

  // The oldest entry has completed with an exception. Nothing retires.
  // The whole buffer is discarded at the next edge.
  assign exc_pend = e_valid[head] & e_done[head] & e_exc[head];

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // The check uses occupancy before this cycle's retirement, so it is conservative by up to COMMIT_W slots.
  assign alloc_ready = ((CNT_W'(DEPTH) - count) >= CNT_W'(DISPATCH_W)) && !flush_in && !exc_pend;

  always_comb begin
    alloc_tag = '0;
    nalloc    = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      alloc_tag[i*TAG_W +: TAG_W] = tail + TAG_W'(i);
      if (alloc_valid[i]) nalloc = nalloc + CNT_W'(1);
    end
    if (!alloc_ready) nalloc = '0;
  end

  // Retirement is a prefix scan from head. The first entry that is not complete, or that carries an exception,
  // stops every younger slot.
  always_comb begin
    commit_valid    = '0;
    commit_areg     = '0;
    commit_preg     = '0;
    commit_old_preg = '0;
    ncommit         = '0;
    chain           = !flush_in;
    cidx            = head;
    for (int i = 0; i < COMMIT_W; i++) begin
      cidx  = head + TAG_W'(i);
      chain = chain & e_valid[cidx] & e_done[cidx] & ~e_exc[cidx];
      commit_valid[i]                     = chain;
      commit_areg[i*AREG_W +: AREG_W]     = e_areg[cidx];
      commit_preg[i*PREG_W +: PREG_W]     = e_preg[cidx];
      commit_old_preg[i*PREG_W +: PREG_W] = e_old[cidx];
      if (chain) ncommit = ncommit + CNT_W'(1);
    end
  end

  // Writeback hits are merged per entry first. Two ports naming the same tag then OR their exception flags
  // instead of the last port overwriting the first. Only entries valid before this edge accept a writeback.
  always_comb begin
    wb_hit     = '0;
    wb_exc_hit = '0;
    wtag       = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      wtag = wb_tag[p*TAG_W +: TAG_W];
      if (wb_valid[p] && e_valid[wtag]) begin
        wb_hit[wtag]     = 1'b1;
        wb_exc_hit[wtag] = wb_exc_hit[wtag] | wb_exc[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    exc_flush <= 1'b0;
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
      e_done  <= '0;
      e_exc   <= '0;
      exc_tag <= '0;
    end else if (flush_in) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
      e_done  <= '0;
      e_exc   <= '0;
    end else if (exc_pend) begin
      exc_flush <= 1'b1;
      exc_tag   <= head;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      e_valid   <= '0;
      e_done    <= '0;
      e_exc     <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wb_hit[e]) begin
          e_done[e] <= 1'b1;
          e_exc[e]  <= e_exc[e] | wb_exc_hit[e];
        end
      end
      for (int i = 0; i < COMMIT_W; i++) begin
        if (commit_valid[i]) e_valid[head + TAG_W'(i)] <= 1'b0;
      end
      // Allocated slots are always invalid before this edge, so they never collide with retiring entries.
      for (int i = 0; i < DISPATCH_W; i++) begin
        if (alloc_ready && alloc_valid[i]) begin
          e_valid[tail + TAG_W'(i)] <= 1'b1;
          e_done[tail + TAG_W'(i)]  <= 1'b0;
          e_exc[tail + TAG_W'(i)]   <= 1'b0;
          e_areg[tail + TAG_W'(i)]  <= alloc_dest_areg[i*AREG_W +: AREG_W];
          e_preg[tail + TAG_W'(i)]  <= alloc_dest_preg[i*PREG_W +: PREG_W];
          e_old[tail + TAG_W'(i)]   <= alloc_old_preg[i*PREG_W +: PREG_W];
        end
      end
      head  <= head + TAG_W'(ncommit);
      tail  <= tail + TAG_W'(nalloc);
      count <= count + nalloc - ncommit;
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mw.sv
module tb_reorder_buffer_mw;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alloc_valid;
  logic        alloc_ready;
  logic [9:0]  alloc_dest_areg;
  logic [11:0] alloc_dest_preg;
  logic [11:0] alloc_old_preg;
  logic [7:0]  alloc_tag;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_tag;
  logic [1:0]  wb_exc;
  logic        flush_in;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_areg;
  logic [11:0] commit_preg;
  logic [11:0] commit_old_preg;
  logic        exc_flush;
  logic [3:0]  exc_tag;
  logic [4:0]  count;
  logic        empty;
  logic        full;

  always #5 clk = ~clk;

  reorder_buffer_mw dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_dest_areg(alloc_dest_areg), .alloc_dest_preg(alloc_dest_preg),
    .alloc_old_preg(alloc_old_preg), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_exc(wb_exc),
    .flush_in(flush_in),
    .commit_valid(commit_valid), .commit_areg(commit_areg),
    .commit_preg(commit_preg), .commit_old_preg(commit_old_preg),
    .exc_flush(exc_flush), .exc_tag(exc_tag),
    .count(count), .empty(empty), .full(full)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One record per cycle: inputs driven after the falling edge, expected outputs seen before the next rising edge.
  // at = expected alloc_tag slot 0.
  // ct = expected head tag when commits are expected, or the expected exc_tag when exc_flush is expected.
  typedef struct packed {
    logic [1:0] av;
    logic [1:0] wbv;
    logic [3:0] t0;
    logic [3:0] t1;
    logic [1:0] wbe;
    logic       fl;
    logic [4:0] cnt;
    logic       rdy;
    logic [1:0] cv;
    logic       xf;
    logic [3:0] at;
    logic [3:0] ct;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int av, input int wbv, input int t0, input int t1, input int wbe,
                     input int fl, input int cnt, input int rdy, input int cv, input int xf,
                     input int at, input int ct);
    vec_t v;
    v.av = 2'(av);   v.wbv = 2'(wbv); v.t0 = 4'(t0); v.t1 = 4'(t1);
    v.wbe = 2'(wbe); v.fl = 1'(fl);   v.cnt = 5'(cnt); v.rdy = 1'(rdy);
    v.cv = 2'(cv);   v.xf = 1'(xf);   v.at = 4'(at);  v.ct = 4'(ct);
    vq.push_back(v);
  endtask

  // The payload is a pure function of the tag it is written to:
  //   areg = tag+1, preg = 32+tag, old_preg = 16+tag.
  task automatic drive(input vec_t v);
    alloc_valid = v.av;
    wb_valid    = v.wbv;
    wb_tag      = {v.t1, v.t0};
    wb_exc      = v.wbe;
    flush_in    = v.fl;
    for (int i = 0; i < 2; i++) begin
      logic [3:0] tg;
      tg = v.at + 4'(i);
      alloc_dest_areg[i*5 +: 5] = {1'b0, tg} + 5'd1;
      alloc_dest_preg[i*6 +: 6] = {2'b10, tg};
      alloc_old_preg[i*6 +: 6]  = {2'b01, tg};
    end
  endtask

  task automatic check_vec(input int n, input vec_t v);
    chk($sformatf("v%0d.count", n), int'(count), int'(v.cnt));
    chk($sformatf("v%0d.alloc_ready", n), int'(alloc_ready), int'(v.rdy));
    chk($sformatf("v%0d.commit_valid", n), int'(commit_valid), int'(v.cv));
    chk($sformatf("v%0d.exc_flush", n), int'(exc_flush), int'(v.xf));
    chk($sformatf("v%0d.empty", n), int'(empty), (v.cnt == 5'd0) ? 1 : 0);
    chk($sformatf("v%0d.full", n), int'(full), (v.cnt == 5'd16) ? 1 : 0);
    chk($sformatf("v%0d.alloc_tag0", n), int'(alloc_tag[3:0]), int'(v.at));
    chk($sformatf("v%0d.alloc_tag1", n), int'(alloc_tag[7:4]), int'(4'(v.at + 4'd1)));
    if (v.xf) chk($sformatf("v%0d.exc_tag", n), int'(exc_tag), int'(v.ct));
    for (int i = 0; i < 2; i++) begin
      if (v.cv[i]) begin
        logic [3:0] tg;
        tg = v.ct + 4'(i);
        chk($sformatf("v%0d.commit_areg%0d", n, i), int'(commit_areg[i*5 +: 5]), int'(tg) + 1);
        chk($sformatf("v%0d.commit_preg%0d", n, i), int'(commit_preg[i*6 +: 6]), 32 + int'(tg));
        chk($sformatf("v%0d.commit_old_preg%0d", n, i), int'(commit_old_preg[i*6 +: 6]), 16 + int'(tg));
      end
    end
  endtask

  initial begin
    rst = 1'b1; alloc_valid = '0; wb_valid = '0; wb_tag = '0; wb_exc = '0; flush_in = 1'b0;
    alloc_dest_areg = '0; alloc_dest_preg = '0; alloc_old_preg = '0;

    // Reset, then idle.
    for (int k = 0; k < 10; k++) add(0,0,0,0,0,0, 0,1,0,0, 0,0);
    // Fill two per cycle, then alloc_valid is ignored while full.
    for (int k = 0; k < 8; k++) add(3,0,0,0,0,0, 2*k,1,0,0, (2*k)%16,0);
    add(3,0,0,0,0,0, 16,0,0,0, 0,0);
    add(3,0,0,0,0,0, 16,0,0,0, 0,0);
    // Complete tag 1 before tag 0: retirement waits for the head.
    add(0,1,1,0,0,0, 16,0,0,0, 0,0);
    add(0,1,0,0,0,0, 16,0,0,0, 0,0);
    add(0,0,0,0,0,0, 16,0,3,0, 0,0);
    add(0,0,0,0,0,0, 14,1,0,0, 0,2);
    // Retire down to two entries, wrap the tail, then wrap the head.
    add(0,3,2,3,0,0,    14,1,0,0, 0,2);
    add(0,3,4,5,0,0,    14,1,3,0, 0,2);
    add(0,3,6,7,0,0,    12,1,3,0, 0,4);
    add(0,3,8,9,0,0,    10,1,3,0, 0,6);
    add(0,3,10,11,0,0,   8,1,3,0, 0,8);
    add(0,3,12,13,0,0,   6,1,3,0, 0,10);
    add(0,0,0,0,0,0,     4,1,3,0, 0,12);
    add(3,0,0,0,0,0,     2,1,0,0, 0,14);
    add(0,3,14,15,0,0,   4,1,0,0, 2,14);
    add(0,3,0,1,0,0,     4,1,3,0, 2,14);
    add(0,0,0,0,0,0,     2,1,3,0, 2,0);
    add(0,0,0,0,0,0,     0,1,0,0, 2,2);
    // Precise exception: tags 2..4 retire, tag 5 excepts.
    add(3,0,0,0,0,0,     0,1,0,0, 2,2);
    add(3,0,0,0,0,0,     2,1,0,0, 4,2);
    add(0,3,2,3,0,0,     4,1,0,0, 6,2);
    add(0,3,4,5,2,0,     4,1,3,0, 6,2);
    add(0,0,0,0,0,0,     2,1,1,0, 6,4);
    add(3,0,0,0,0,0,     1,0,0,0, 6,5);
    add(0,0,0,0,0,0,     0,1,0,1, 0,5);
    add(0,0,0,0,0,0,     0,1,0,0, 0,0);
    // Both ports name tag 0; only port 0 reports the exception.
    add(3,0,0,0,0,0,     0,1,0,0, 0,0);
    add(0,3,0,0,1,0,     2,1,0,0, 2,0);
    add(0,0,0,0,0,0,     2,0,0,0, 2,0);
    add(0,0,0,0,0,0,     0,1,0,1, 0,0);
    // External flush with 6 entries, alloc and WB in the same cycle.
    add(3,0,0,0,0,0,     0,1,0,0, 0,0);
    add(3,0,0,0,0,0,     2,1,0,0, 2,0);
    add(3,0,0,0,0,0,     4,1,0,0, 4,0);
    add(0,3,0,1,0,0,     6,1,0,0, 6,0);
    add(3,3,2,3,0,1,     6,0,0,0, 6,0);
    add(0,0,0,0,0,0,     0,1,0,0, 0,0);
    // WB to an invalid entry, and WB in the same cycle as the allocation, are both ignored.
    add(0,1,0,0,0,0,     0,1,0,0, 0,0);
    add(3,1,0,0,0,0,     0,1,0,0, 0,0);
    add(0,3,0,1,0,0,     2,1,0,0, 2,0);
    add(0,0,0,0,0,0,     2,1,3,0, 2,0);
    add(0,0,0,0,0,0,     0,1,0,0, 2,2);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.exc_tag", int'(exc_tag), 0);

    for (int n = 0; n < vq.size(); n++) begin
      @(negedge clk);
      drive(vq[n]);
      #1;
      check_vec(n, vq[n]);
    end

    // Reset in the middle of operation discards live entries.
    @(negedge clk);
    alloc_valid = 2'b11; wb_valid = '0; flush_in = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst.count_before", int'(count), 2);
    alloc_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst.count", int'(count), 0);
    chk("midrst.empty", int'(empty), 1);
    chk("midrst.alloc_ready", int'(alloc_ready), 1);
    chk("midrst.commit_valid", int'(commit_valid), 0);
    chk("midrst.alloc_tag0", int'(alloc_tag[3:0]), 0);
    chk("midrst.exc_flush", int'(exc_flush), 0);

    // A single-slot allocation advances the tail by one.
    alloc_valid = 2'b01;
    @(negedge clk);
    alloc_valid = 2'b00;
    #1;
    chk("single.count", int'(count), 1);
    chk("single.alloc_tag0", int'(alloc_tag[3:0]), 1);
    chk("single.empty", int'(empty), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
